frame_loader: RTL and testbench
===============================

# frame_loader

Streaming-to-parallel frame assembler that sits in front of the mini MobileNet network. Accepts one pixel channel value per handshake beat over a valid/ready stream and writes it into a full-frame register buffer. Once a complete INPUT_SIZE × INPUT_SIZE × INPUT_CHANNELS frame is stored, it presents the frame on a packed bus with the same layout as the network's image input. It holds that frame stable until the consumer acknowledges it.

## Interface

Parameters:
- INPUT_SIZE, 32, frame width and height (square)
- INPUT_CHANNELS, 3, channels per pixel
- PX_SIZE, 8, bits per channel value

Ports:
- clk, input, 1, single clock; all logic on the rising edge
- rst_n, input, 1, reset, synchronous and active-low
- s_valid, input, 1, stream beat valid
- s_ready, output, 1, loader can accept a beat
- s_data, input, PX_SIZE, channel value
- s_sof, input, 1, marks the beat as frame element 0 (row 0, col 0, ch 0)
- img_out, output, [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0], assembled frame, indexed [row][col][ch]
- frame_valid, output, 1, img_out holds a complete frame
- frame_ack, input, 1, consumer has taken the frame
- sync_err, output, 1, one-cycle pulse when s_sof arrives mid-frame

## Operation

- Beat order is channel fastest, then column, then row: element k maps to ch = k mod C, col = (k / C) mod N, row = k / (C·N). A frame is N·N·C beats (3072 at the defaults).
- Element position is tracked by separate ch, col and row counters. Each counter is $clog2 of its range wide, minimum 1 bit.
  - ch wraps to 0 at C-1 and carries into col.
  - col wraps to 0 at N-1 and carries into row.
- States:
  - LOAD: s_ready=1. Each transfer (s_valid && s_ready) writes s_data into img_out[row][col][ch] and advances the counters.
    - A transfer at the last element (row=N-1, col=N-1, ch=C-1) resets the counters to 0 and moves to FULL.
  - FULL: s_ready=0 and frame_valid=1. img_out does not change.
    - frame_ack=1 moves to LOAD.
    - frame_ack in LOAD is ignored.
- Resync: a transfer with s_sof=1 while the counters are non-zero is a mid-frame start.
  - sync_err=1 in the next cycle.
  - The beat is written to element 0 and the counters become element 1.
  - Earlier partial data stays in the buffer and is overwritten as the new frame fills.
- A transfer with s_sof=1 at element 0 is normal. s_sof is optional: beats at element 0 without s_sof are accepted as frame starts.
- When N·N·C = 1, the single transfer completes the frame.
- Reset (rst_n=0 at an edge), including mid-frame:
  - state=LOAD, counters=0.
  - s_ready=0, frame_valid=0, sync_err=0, img_out all zeros.
  - s_ready rises to 1 on the first edge with rst_n=1.
  - Any partial frame is discarded.

## Timing

- All outputs are registered. There is no combinational path from inputs to outputs.
- Write latency: a beat transferred at edge t is visible on img_out after edge t.
- Frame completion: the last transfer at edge t gives frame_valid=1 and s_ready=0 after t. The loader accepts no beat in the cycle following the last one.
- Release: frame_ack=1 sampled at edge t gives frame_valid=0 and s_ready=1 after t. The next transfer can occur at edge t+1.
- Sustained throughput is 1 beat/cycle within a frame. Each frame costs N·N·C + 1 + (ack wait) cycles.
- s_ready does not depend on s_valid, and there is no s_ready bubble within a frame.
- sync_err is high for exactly one cycle per offending beat.

## Structure

- Shared package minimobilenet_pkg holds the following; the loader and the network both import it so frame layout cannot diverge:
  - INPUT_SIZE, INPUT_CHANNELS and PX_SIZE defaults
  - the frame typedef (packed [N][N][C][PX_SIZE])
  - the state enum {LOAD, FULL}
- One sub-module: frame_addr_counter. It holds the ch/col/row cascade with inputs inc and clear, and outputs ch, col, row and last. frame_loader contains the FSM, the buffer write decode, sync_err and the handshake.

## Test plan

- Basic fill: reset, then 3072 beats with s_data = k[7:0], s_valid held high, no ack.
  - frame_valid rises exactly 1 cycle after beat 3071, and s_ready falls at the same time.
  - img_out[0][0][0]=0x00, img_out[0][1][2]=0x05, img_out[31][31][2]=0xFF (3071 mod 256).
- Backpressure and hold: after a full frame, drive s_valid=1 with s_data=0xAA for 10 cycles, then frame_ack for 1 cycle.
  - No writes occur, and img_out is unchanged.
  - frame_valid=0 and s_ready=1 one cycle after the ack.
  - The next beat lands at [0][0][0].
- Gapped stream: toggle s_valid randomly at 50%.
  - The frame is identical to the basic fill.
  - The frame_valid rise follows the 3072nd transfer by exactly 1 cycle.
- Resync: send 100 beats, then a beat with s_sof=1 and s_data=0x5A, then 3071 more beats.
  - sync_err pulses once, 1 cycle after the sof beat.
  - img_out[0][0][0]=0x5A.
  - frame_valid rises after 3072 beats counted from the sof beat.
- Reset mid-frame: send 500 beats, then rst_n=0 for 2 cycles.
  - img_out is all zeros, and frame_valid=0 and s_ready=0 during reset.
  - s_ready=1 one cycle after release.
  - A full new frame then loads correctly from element 0.
- Small config: N=2, C=1.
  - Four beats 1, 2, 3, 4 give img_out [0][0]=1, [0][1]=2, [1][0]=3, [1][1]=4.
  - A frame_ack in LOAD has no effect.

Source files
------------

// File: rtl/minimobilenet_pkg.sv
// Shared definitions for the mini MobileNet front end: frame geometry
// defaults, the packed frame layout and the loader state encoding.
package minimobilenet_pkg;

  localparam int unsigned INPUT_SIZE     = 32;
  localparam int unsigned INPUT_CHANNELS = 3;
  localparam int unsigned PX_SIZE        = 8;

  // Image layout shared with the network input: [row][col][ch][bit]
  typedef logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] frame_t;

  typedef enum logic {LOAD, FULL} loader_state_t;

  // Counter width for a range, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/frame_addr_counter.sv
// Element position tracker: channel fastest, then column, then row.
// clear restarts the cascade at element 0; clear with inc lands on element 1.
module frame_addr_counter #(
  parameter int unsigned N     = 32,
  parameter int unsigned C     = 3,
  parameter int unsigned CH_W  = minimobilenet_pkg::cnt_width(C),
  parameter int unsigned POS_W = minimobilenet_pkg::cnt_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CH_W-1:0]  ch,
  output logic [POS_W-1:0] col,
  output logic [POS_W-1:0] row,
  output logic             last
);

  logic [CH_W-1:0]  ch_q, ch_base, ch_d;
  logic [POS_W-1:0] col_q, col_base, col_d;
  logic [POS_W-1:0] row_q, row_base, row_d;

  // Next position: optional restart, then one step of the ch->col->row cascade
  always_comb begin
    ch_base  = clear ? '0 : ch_q;
    col_base = clear ? '0 : col_q;
    row_base = clear ? '0 : row_q;
    ch_d     = ch_base;
    col_d    = col_base;
    row_d    = row_base;
    if (inc) begin
      if (ch_base == CH_W'(C - 1)) begin
        ch_d = '0;
        if (col_base == POS_W'(N - 1)) begin
          col_d = '0;
          if (row_base == POS_W'(N - 1)) begin
            row_d = '0;
          end else begin
            row_d = row_base + POS_W'(1);
          end
        end else begin
          col_d = col_base + POS_W'(1);
        end
      end else begin
        ch_d = ch_base + CH_W'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_q  <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      ch_q  <= ch_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign ch   = ch_q;
  assign col  = col_q;
  assign row  = row_q;
  assign last = (ch_q == CH_W'(C - 1)) && (col_q == POS_W'(N - 1)) && (row_q == POS_W'(N - 1));

endmodule

// File: rtl/frame_loader.sv
// Streaming-to-parallel frame assembler: collects one channel value per
// beat into a full-frame buffer and holds the completed frame until acked.
module frame_loader #(
  parameter int unsigned INPUT_SIZE     = minimobilenet_pkg::INPUT_SIZE,
  parameter int unsigned INPUT_CHANNELS = minimobilenet_pkg::INPUT_CHANNELS,
  parameter int unsigned PX_SIZE        = minimobilenet_pkg::PX_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [PX_SIZE-1:0]  s_data,
  input  logic                s_sof,
  output logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] img_out,
  output logic                frame_valid,
  input  logic                frame_ack,
  output logic                sync_err
);

  import minimobilenet_pkg::*;

  localparam int unsigned CH_W  = cnt_width(INPUT_CHANNELS);
  localparam int unsigned POS_W = cnt_width(INPUT_SIZE);

  loader_state_t state_q, state_d;

  logic [CH_W-1:0]  ch, wr_ch;
  logic [POS_W-1:0] col, row, wr_col, wr_row;
  logic             last, at_first;
  logic             xfer, resync, last_xfer;
  logic             ready_d, valid_d, err_d;

  // s_ready is registered and only high in LOAD, so a transfer implies LOAD
  assign xfer      = s_valid && s_ready;
  assign at_first  = (ch == '0) && (col == '0) && (row == '0);
  assign resync    = xfer && s_sof && !at_first;
  // A resync beat is element 0 regardless of where the counters were
  assign last_xfer = xfer && last && !resync;

  assign wr_ch  = resync ? '0 : ch;
  assign wr_col = resync ? '0 : col;
  assign wr_row = resync ? '0 : row;

  frame_addr_counter #(
    .N     (INPUT_SIZE),
    .C     (INPUT_CHANNELS),
    .CH_W  (CH_W),
    .POS_W (POS_W)
  ) u_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (xfer),
    .clear (resync),
    .ch    (ch),
    .col   (col),
    .row   (row),
    .last  (last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: fill until the last element, then hold until acknowledged
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: if (last_xfer) state_d = FULL;
      FULL: if (frame_ack) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Output decode from the upcoming state so registered outputs track it
  always_comb begin
    ready_d = (state_d == LOAD);
    valid_d = (state_d == FULL);
    err_d   = resync;
  end

  // Registered outputs and frame buffer write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ready     <= 1'b0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      img_out     <= '0;
    end else begin
      s_ready     <= ready_d;
      frame_valid <= valid_d;
      sync_err    <= err_d;
      if (xfer) begin
        img_out[wr_row][wr_col][wr_ch] <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: default 32x32x3 instance plus a 2x2x1 instance.
module tb_frame_loader;

  import minimobilenet_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration
  logic       rst_n, s_valid, s_ready, s_sof, frame_valid, frame_ack, sync_err;
  logic [7:0] s_data;
  frame_t     img;

  frame_loader dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .img_out(img), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .sync_err(sync_err)
  );

  // Small configuration N=2, C=1
  logic                       rst2_n, s2_valid, s2_ready, s2_sof, fv2, ack2, err2;
  logic [7:0]                 s2_data;
  logic [1:0][1:0][0:0][7:0]  img2;

  frame_loader #(.INPUT_SIZE(2), .INPUT_CHANNELS(1), .PX_SIZE(8)) dut_small (
    .clk(clk), .rst_n(rst2_n), .s_valid(s2_valid), .s_ready(s2_ready),
    .s_data(s2_data), .s_sof(s2_sof), .img_out(img2), .frame_valid(fv2),
    .frame_ack(ack2), .sync_err(err2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int err_pulses = 0;
  int err2_pulses = 0;

  always @(negedge clk) begin
    if (sync_err) err_pulses++;
    if (err2) err2_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Push n transfers with data (start+i)[7:0]; returns at the negedge one
  // cycle after the last transfer with s_valid dropped.
  task automatic send_beats(input int n, input int start, input bit gapped, input bit sof_first);
    int sent = 0;
    int cyc  = 0;
    while (sent < n && cyc < 20000) begin
      @(negedge clk);
      if (gapped && $urandom_range(1, 0) == 0) begin
        s_valid = 1'b0;
        s_sof   = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = 8'(start + sent);
        s_sof   = sof_first && (sent == 0);
        if (s_ready) begin
          if (sent == n - 1) check("fv_low_at_last_beat", 32'(frame_valid), 32'd0);
          sent++;
        end
      end
      cyc++;
    end
    if (sent < n) check("beat_timeout", 32'(sent), 32'(n));
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic ack_frame();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; frame_ack = 1'b0;
    rst2_n = 1'b0; s2_valid = 1'b0; s2_sof = 1'b0; s2_data = '0; ack2 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_fv", 32'(frame_valid), 32'd0);
    check("rst_err", 32'(sync_err), 32'd0);
    check("rst_img_zero", 32'(img == '0), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(s_ready), 32'd1);

    // Basic fill, data = k[7:0]
    send_beats(3072, 0, 1'b0, 1'b0);
    check("fill_fv", 32'(frame_valid), 32'd1);
    check("fill_ready", 32'(s_ready), 32'd0);
    check("fill_000", 32'(img[0][0][0]), 32'h00);
    check("fill_012", 32'(img[0][1][2]), 32'h05);
    check("fill_100", 32'(img[1][0][0]), 32'h60);
    check("fill_31_31_2", 32'(img[31][31][2]), 32'hFF);

    // Backpressure and hold
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'hAA;
      check("hold_ready", 32'(s_ready), 32'd0);
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("hold_fv", 32'(frame_valid), 32'd1);
    check("hold_000", 32'(img[0][0][0]), 32'h00);
    check("hold_012", 32'(img[0][1][2]), 32'h05);
    ack_frame();
    check("ack_fv", 32'(frame_valid), 32'd0);
    check("ack_ready", 32'(s_ready), 32'd1);
    send_beats(1, 8'h33, 1'b0, 1'b0);
    check("next_000", 32'(img[0][0][0]), 32'h33);
    check("next_001_kept", 32'(img[0][0][1]), 32'h01);
    check("next_fv", 32'(frame_valid), 32'd0);
    send_beats(3071, 1, 1'b0, 1'b0);
    check("rest_fv", 32'(frame_valid), 32'd1);
    check("rest_001", 32'(img[0][0][1]), 32'h01);

    // Gapped stream
    ack_frame();
    send_beats(3072, 0, 1'b1, 1'b0);
    check("gap_fv", 32'(frame_valid), 32'd1);
    check("gap_000", 32'(img[0][0][0]), 32'h00);
    check("gap_012", 32'(img[0][1][2]), 32'h05);
    check("gap_31_31_2", 32'(img[31][31][2]), 32'hFF);
    check("gap_err_none", 32'(err_pulses), 32'd0);

    // Resync mid-frame
    ack_frame();
    send_beats(100, 0, 1'b0, 1'b0);
    send_beats(1, 8'h5A, 1'b0, 1'b1);
    check("resync_err_pulse", 32'(sync_err), 32'd1);
    check("resync_000", 32'(img[0][0][0]), 32'h5A);
    @(negedge clk);
    check("resync_err_drop", 32'(sync_err), 32'd0);
    send_beats(3071, 8'h5B, 1'b0, 1'b0);
    check("resync_fv", 32'(frame_valid), 32'd1);
    check("resync_001", 32'(img[0][0][1]), 32'h5B);
    check("resync_31_31_2", 32'(img[31][31][2]), 32'h59);
    check("resync_err_count", 32'(err_pulses), 32'd1);

    // Reset mid-frame
    ack_frame();
    send_beats(500, 8'h10, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mrst_img_zero", 32'(img == '0), 32'd1);
    check("mrst_fv", 32'(frame_valid), 32'd0);
    check("mrst_ready", 32'(s_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_ready_up", 32'(s_ready), 32'd1);
    send_beats(3072, 8'h20, 1'b0, 1'b0);
    check("mrst_fv_full", 32'(frame_valid), 32'd1);
    check("mrst_000", 32'(img[0][0][0]), 32'h20);
    check("mrst_012", 32'(img[0][1][2]), 32'h25);
    check("mrst_31_31_2", 32'(img[31][31][2]), 32'h1F);

    // Small configuration
    rst2_n = 1'b1;
    @(negedge clk);
    ack2 = 1'b1;
    @(negedge clk);
    ack2 = 1'b0;
    check("small_ack_load_ready", 32'(s2_ready), 32'd1);
    check("small_ack_load_fv", 32'(fv2), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("small_ready_beat", 32'(s2_ready), 32'd1);
      s2_valid = 1'b1;
      s2_data  = 8'(i + 1);
      ack2     = (i == 1);
    end
    @(negedge clk);
    s2_valid = 1'b0;
    ack2     = 1'b0;
    check("small_fv", 32'(fv2), 32'd1);
    check("small_ready_low", 32'(s2_ready), 32'd0);
    check("small_00", 32'(img2[0][0][0]), 32'd1);
    check("small_01", 32'(img2[0][1][0]), 32'd2);
    check("small_10", 32'(img2[1][0][0]), 32'd3);
    check("small_11", 32'(img2[1][1][0]), 32'd4);
    check("small_err_none", 32'(err2_pulses), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
